// File: rtl/alien_pkg.sv
// Shared types and constants for the alien laser launcher: FSM states,
// formation size and the default sprite geometry.
package alien_pkg;

    typedef enum logic [1:0] {
        S_IDLE,
        S_SCAN,
        S_FIRE,
        S_NONE
    } state_t;

    localparam int NUM_ALIENS       = 20;
    localparam int ALIENS_PER_ROW   = 5;

    localparam int ALIEN_WIDTH_DEF  = 40;
    localparam int ALIEN_HEIGHT_DEF = 21;
    localparam int ALIEN_GAP_DEF    = 21;
    localparam int LASER_WIDTH_DEF  = 5;

    localparam logic [4:0] LAST_IDX = 5'(NUM_ALIENS - 1);

    // Fold a 5-bit value into the 0..NUM_ALIENS-1 index range.
    function automatic logic [4:0] wrap_idx(input logic [4:0] raw);
        return (raw < 5'(NUM_ALIENS)) ? raw : raw - 5'(NUM_ALIENS);
    endfunction

endpackage

// File: rtl/alien_fire_if.sv
// Request/result bundle between the game logic (master) and the alien
// laser launcher (slave), including the combinational alive-table lookup.
interface alien_fire_if;

    logic       fire_req;
    logic [9:0] alien_group_x;
    logic [8:0] alien_group_y;
    logic       alien_alive;
    logic [4:0] which_alien_out;
    logic [9:0] laser_x;
    logic [8:0] laser_y;
    logic       busy;
    logic       done;
    logic       fired;

    modport master (
        output fire_req, alien_group_x, alien_group_y, alien_alive,
        input  which_alien_out, laser_x, laser_y, busy, done, fired
    );

    modport slave (
        input  fire_req, alien_group_x, alien_group_y, alien_alive,
        output which_alien_out, laser_x, laser_y, busy, done, fired
    );

endinterface

// File: rtl/alien_pos.sv
// Combinational map from formation origin and alien index to the spawn
// point of a laser centred under that alien. Coordinates wrap, no clamping.
module alien_pos
    import alien_pkg::*;
#(
    parameter int ALIEN_WIDTH  = ALIEN_WIDTH_DEF,
    parameter int ALIEN_HEIGHT = ALIEN_HEIGHT_DEF,
    parameter int ALIEN_GAP    = ALIEN_GAP_DEF,
    parameter int LASER_WIDTH  = LASER_WIDTH_DEF
) (
    input  logic [9:0] group_x,
    input  logic [8:0] group_y,
    input  logic [4:0] idx,
    output logic [9:0] spawn_x,
    output logic [8:0] spawn_y
);

    localparam int X_STEP = ALIEN_WIDTH + ALIEN_GAP;
    localparam int Y_STEP = ALIEN_HEIGHT + ALIEN_GAP;
    localparam int X_OFF  = (ALIEN_WIDTH - LASER_WIDTH) / 2;

    logic [2:0] col;
    logic [2:0] row;

    always_comb begin
        col     = 3'(idx % 5'(ALIENS_PER_ROW));
        row     = 3'(idx / 5'(ALIENS_PER_ROW));
        spawn_x = group_x + 10'(int'(col) * X_STEP) + 10'(X_OFF);
        spawn_y = group_y + 9'(int'(row) * Y_STEP) + 9'(ALIEN_HEIGHT);
    end

endmodule

// File: rtl/alien_fire.sv
// Alien laser launcher: walks the formation downward from a start index until
// it finds a live alien, then reports its laser spawn point.
// Optional ALIEN_FIRE_RANDOM_EN: start index taken from a free-running 5-bit LFSR.
module alien_fire
    import alien_pkg::*;
#(
    parameter int ALIEN_WIDTH  = ALIEN_WIDTH_DEF,
    parameter int ALIEN_HEIGHT = ALIEN_HEIGHT_DEF,
    parameter int ALIEN_GAP    = ALIEN_GAP_DEF,
    parameter int LASER_WIDTH  = LASER_WIDTH_DEF
) (
    input  logic         clock,
    input  logic         reset,
    alien_fire_if.slave  af
);

    state_t     state_q, state_d;
    logic [4:0] idx_q, idx_d;
    logic [4:0] cnt_q, cnt_d;
    logic [9:0] gx_q, gx_d;
    logic [8:0] gy_q, gy_d;
    logic [9:0] laser_x_q, laser_x_d;
    logic [8:0] laser_y_q, laser_y_d;
    logic [4:0] start_idx;
    logic [9:0] spawn_x;
    logic [8:0] spawn_y;

`ifdef ALIEN_FIRE_RANDOM_EN
    logic [4:0] lfsr_q, lfsr_d;

    // x^5 + x^3 + 1, shifting left; never reaches the all-zero lock-up state.
    always_comb lfsr_d = {lfsr_q[3:0], lfsr_q[4] ^ lfsr_q[2]};

    always_ff @(posedge clock or posedge reset) begin
        if (reset) lfsr_q <= 5'b00001;
        else       lfsr_q <= lfsr_d;
    end

    always_comb start_idx = wrap_idx(lfsr_q);
`else
    always_comb start_idx = LAST_IDX;
`endif

    alien_pos #(
        .ALIEN_WIDTH  (ALIEN_WIDTH),
        .ALIEN_HEIGHT (ALIEN_HEIGHT),
        .ALIEN_GAP    (ALIEN_GAP),
        .LASER_WIDTH  (LASER_WIDTH)
    ) u_pos (
        .group_x (gx_q),
        .group_y (gy_q),
        .idx     (idx_q),
        .spawn_x (spawn_x),
        .spawn_y (spawn_y)
    );

    always_comb begin
        state_d   = state_q;
        idx_d     = idx_q;
        cnt_d     = cnt_q;
        gx_d      = gx_q;
        gy_d      = gy_q;
        laser_x_d = laser_x_q;
        laser_y_d = laser_y_q;
        case (state_q)
            S_IDLE: begin
                if (af.fire_req) begin
                    gx_d    = af.alien_group_x;
                    gy_d    = af.alien_group_y;
                    idx_d   = start_idx;
                    cnt_d   = '0;
                    state_d = S_SCAN;
                end
            end
            S_SCAN: begin
                // cnt_q counts aliens already rejected, so 19 means this is the 20th look.
                if (af.alien_alive) begin
                    laser_x_d = spawn_x;
                    laser_y_d = spawn_y;
                    state_d   = S_FIRE;
                end else if (cnt_q == LAST_IDX) begin
                    state_d = S_NONE;
                end else begin
                    idx_d = (idx_q == '0) ? LAST_IDX : idx_q - 5'd1;
                    cnt_d = cnt_q + 5'd1;
                end
            end
            S_FIRE:  state_d = S_IDLE;
            S_NONE:  state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_q   <= S_IDLE;
            idx_q     <= LAST_IDX;
            cnt_q     <= '0;
            laser_x_q <= '0;
            laser_y_q <= '0;
        end else begin
            state_q   <= state_d;
            idx_q     <= idx_d;
            cnt_q     <= cnt_d;
            laser_x_q <= laser_x_d;
            laser_y_q <= laser_y_d;
        end
    end

    // The latched origin is only consumed during a scan it was loaded for.
    always_ff @(posedge clock) begin
        gx_q <= gx_d;
        gy_q <= gy_d;
    end

    assign af.which_alien_out = idx_q;
    assign af.laser_x         = laser_x_q;
    assign af.laser_y         = laser_y_q;
    assign af.busy            = (state_q == S_SCAN);
    assign af.done            = (state_q == S_FIRE) || (state_q == S_NONE);
    assign af.fired           = (state_q == S_FIRE);

endmodule

// File: tb/tb_alien_fire.sv
// Self-checking bench for alien_fire: directed scenarios plus randomized
// formations checked against a behavioural scan model.
module tb_alien_fire;

    logic        clock = 1'b0;
    logic        reset = 1'b1;
    logic [19:0] alive_mask = '0;
    int          total = 0;
    int          bad   = 0;
    int          model_lx = 0;
    int          model_ly = 0;
    int          visited[$];

    alien_fire_if af();

    alien_fire dut (
        .clock (clock),
        .reset (reset),
        .af    (af)
    );

    assign af.alien_alive = alive_mask[af.which_alien_out];

    always #5 clock = ~clock;

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    function automatic int exp_x(input int gx, input int idx);
        return (gx + (idx % 5) * (40 + 21) + (40 - 5) / 2) % 1024;
    endfunction

    function automatic int exp_y(input int gy, input int idx);
        return (gy + (idx / 5) * (21 + 21) + 21) % 512;
    endfunction

    // Index of the k-th alien examined (k from 1) when walking down from 'start'.
    function automatic int kth_idx(input int start, input int k);
        return (start - (k - 1) + 40) % 20;
    endfunction

    // First live alien in examination order: returns k (1..20) or 0 if none.
    function automatic int first_alive(input logic [19:0] m, input int start);
        for (int k = 1; k <= 20; k++)
            if (m[kth_idx(start, k)]) return k;
        return 0;
    endfunction

    task automatic launch(input int budget, input bit scramble,
                          output int edges, output bit got_done);
        visited.delete();
        @(negedge clock);
        af.fire_req = 1'b1;
        @(posedge clock);
        edges = 1;
        @(negedge clock);
        af.fire_req = 1'b0;
        got_done = 1'b0;
        for (int i = 0; i < budget; i++) begin
            if (af.done) begin
                got_done = 1'b1;
                break;
            end
            if (af.busy) visited.push_back(int'(af.which_alien_out));
            if (scramble) begin
                af.alien_group_x = 10'($urandom);
                af.alien_group_y = 9'($urandom);
            end
            @(posedge clock);
            edges++;
            @(negedge clock);
        end
    endtask

    task automatic test_reset;
        af.fire_req      = 1'b0;
        af.alien_group_x = 10'd200;
        af.alien_group_y = 9'd200;
        reset = 1'b1;
        repeat (2) @(posedge clock);
        @(negedge clock);
        total++; if (af.which_alien_out !== 5'd19) begin bad++; $display("FAIL reset_which: got %0d want 19", af.which_alien_out); end
        total++; if (af.laser_x !== 10'd0) begin bad++; $display("FAIL reset_laser_x: got %0d want 0", af.laser_x); end
        total++; if (af.laser_y !== 9'd0) begin bad++; $display("FAIL reset_laser_y: got %0d want 0", af.laser_y); end
        total++; if (af.busy !== 1'b0) begin bad++; $display("FAIL reset_busy: got %b want 0", af.busy); end
        total++; if ({af.done, af.fired} !== 2'b00) begin bad++; $display("FAIL reset_done_fired: got %b want 00", {af.done, af.fired}); end
        reset = 1'b0;
        @(negedge clock);
    endtask

`ifndef ALIEN_FIRE_RANDOM_EN
    task automatic test_all_alive;
        int edges; bit ok;
        alive_mask = '1;
        af.alien_group_x = 10'd200;
        af.alien_group_y = 9'd200;
        launch(40, 1'b0, edges, ok);
        total++; if (!ok) begin bad++; $display("FAIL all_alive_done: got none want pulse"); end
        total++; if (edges != 2) begin bad++; $display("FAIL all_alive_latency: got %0d want 2", edges); end
        total++; if (af.fired !== 1'b1) begin bad++; $display("FAIL all_alive_fired: got %b want 1", af.fired); end
        total++; if (af.laser_x !== 10'd461) begin bad++; $display("FAIL all_alive_x: got %0d want 461", af.laser_x); end
        total++; if (af.laser_y !== 9'd347) begin bad++; $display("FAIL all_alive_y: got %0d want 347", af.laser_y); end
        total++; if (af.which_alien_out !== 5'd19) begin bad++; $display("FAIL all_alive_which: got %0d want 19", af.which_alien_out); end
        model_lx = 461; model_ly = 347;
    endtask

    task automatic test_only_zero;
        int edges; bit ok; int seq_bad;
        alive_mask = 20'h00001;
        af.alien_group_x = 10'd200;
        af.alien_group_y = 9'd200;
        launch(40, 1'b0, edges, ok);
        total++; if (!ok || edges != 21) begin bad++; $display("FAIL only0_latency: got %0d want 21", edges); end
        total++; if (af.fired !== 1'b1) begin bad++; $display("FAIL only0_fired: got %b want 1", af.fired); end
        total++; if (af.laser_x !== 10'd217) begin bad++; $display("FAIL only0_x: got %0d want 217", af.laser_x); end
        total++; if (af.laser_y !== 9'd221) begin bad++; $display("FAIL only0_y: got %0d want 221", af.laser_y); end
        seq_bad = (visited.size() == 20) ? 0 : 1;
        foreach (visited[i]) if (i < 20 && visited[i] != 19 - i) seq_bad++;
        total++; if (seq_bad != 0) begin bad++; $display("FAIL only0_visit_order: got %0d visits %0d wrong want 20 visits 0 wrong", visited.size(), seq_bad); end
        model_lx = 217; model_ly = 221;
    endtask

    task automatic test_none_alive;
        int edges; bit ok;
        alive_mask = '0;
        af.alien_group_x = 10'd300;
        af.alien_group_y = 9'd100;
        launch(40, 1'b0, edges, ok);
        total++; if (!ok || edges != 21) begin bad++; $display("FAIL none_latency: got %0d want 21", edges); end
        total++; if (af.fired !== 1'b0) begin bad++; $display("FAIL none_fired: got %b want 0", af.fired); end
        total++; if (af.laser_x !== 10'(model_lx)) begin bad++; $display("FAIL none_hold_x: got %0d want %0d", af.laser_x, model_lx); end
        total++; if (af.laser_y !== 9'(model_ly)) begin bad++; $display("FAIL none_hold_y: got %0d want %0d", af.laser_y, model_ly); end
    endtask

    task automatic test_requeue;
        int dones = 0;
        alive_mask = '0;
        @(negedge clock);
        af.fire_req = 1'b1;
        repeat (10) @(negedge clock);
        total++; if (af.busy !== 1'b1) begin bad++; $display("FAIL requeue_busy: got %b want 1", af.busy); end
        af.fire_req = 1'b0;
        for (int i = 0; i < 40; i++) begin
            if (af.done) dones++;
            @(negedge clock);
        end
        total++; if (dones != 1) begin bad++; $display("FAIL requeue_done_count: got %0d want 1", dones); end
    endtask

    task automatic test_reset_mid;
        int dones = 0;
        alive_mask = '0;
        @(negedge clock);
        af.fire_req = 1'b1;
        @(posedge clock);
        @(negedge clock);
        af.fire_req = 1'b0;
        repeat (4) @(posedge clock);
        #2 reset = 1'b1;
        #1;
        total++; if (af.busy !== 1'b0) begin bad++; $display("FAIL midreset_busy: got %b want 0", af.busy); end
        total++; if (af.which_alien_out !== 5'd19) begin bad++; $display("FAIL midreset_which: got %0d want 19", af.which_alien_out); end
        total++; if ({af.laser_x, af.laser_y} !== 19'd0) begin bad++; $display("FAIL midreset_laser: got %0d/%0d want 0/0", af.laser_x, af.laser_y); end
        total++; if ({af.done, af.fired} !== 2'b00) begin bad++; $display("FAIL midreset_done_fired: got %b want 00", {af.done, af.fired}); end
        @(negedge clock);
        reset = 1'b0;
        for (int i = 0; i < 30; i++) begin
            if (af.done || af.busy) dones++;
            @(negedge clock);
        end
        total++; if (dones != 0) begin bad++; $display("FAIL midreset_activity: got %0d want 0", dones); end
        model_lx = 0; model_ly = 0;
    endtask

    task automatic test_random;
        int edges; bit ok; int gx, gy, k, idx;
        for (int n = 0; n < 25; n++) begin
            gx = int'($urandom_range(0, 1023));
            gy = int'($urandom_range(0, 511));
            alive_mask = (n % 6 == 5) ? 20'h0 : 20'($urandom & $urandom & $urandom);
            af.alien_group_x = 10'(gx);
            af.alien_group_y = 9'(gy);
            launch(40, 1'b1, edges, ok);
            k = first_alive(alive_mask, 19);
            if (k != 0) begin
                idx = kth_idx(19, k);
                model_lx = exp_x(gx, idx);
                model_ly = exp_y(gy, idx);
            end
            total++; if (!ok || edges != ((k == 0) ? 21 : k + 1)) begin bad++; $display("FAIL rand_latency[%0d]: got %0d want %0d", n, edges, (k == 0) ? 21 : k + 1); end
            total++; if (af.fired !== (k != 0)) begin bad++; $display("FAIL rand_fired[%0d]: got %b want %b", n, af.fired, k != 0); end
            total++; if (af.laser_x !== 10'(model_lx) || af.laser_y !== 9'(model_ly)) begin bad++; $display("FAIL rand_coords[%0d]: got %0d/%0d want %0d/%0d", n, af.laser_x, af.laser_y, model_lx, model_ly); end
            if (k != 0) begin
                total++; if (af.which_alien_out !== 5'(idx)) begin bad++; $display("FAIL rand_which[%0d]: got %0d want %0d", n, af.which_alien_out, idx); end
            end
        end
    endtask
`else
    task automatic test_back_to_back;
        int edges; bit ok; int distinct = 0;
        bit seen[32];
        foreach (seen[i]) seen[i] = 1'b0;
        alive_mask = '1;
        af.alien_group_x = 10'd200;
        af.alien_group_y = 9'd200;
        for (int n = 0; n < 8; n++) begin
            launch(40, 1'b0, edges, ok);
            total++; if (!ok || edges != 2 || af.fired !== 1'b1) begin bad++; $display("FAIL b2b_fire[%0d]: got edges %0d fired %b want 2/1", n, edges, af.fired); end
            total++; if (af.which_alien_out >= 5'd20) begin bad++; $display("FAIL b2b_range[%0d]: got %0d want <20", n, af.which_alien_out); end
            seen[af.which_alien_out] = 1'b1;
        end
        foreach (seen[i]) if (seen[i]) distinct++;
        total++; if (distinct < 2) begin bad++; $display("FAIL b2b_distinct: got %0d want >=2", distinct); end
    endtask
`endif

    initial begin
        af.fire_req      = 1'b0;
        af.alien_group_x = '0;
        af.alien_group_y = '0;
        test_reset();
`ifndef ALIEN_FIRE_RANDOM_EN
        test_all_alive();
        test_only_zero();
        test_none_alive();
        test_requeue();
        test_reset_mid();
        test_random();
`else
        test_back_to_back();
`endif
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
